// File: rtl/l1_reg_mem_mp_if.sv
// l1_reg_mem_mp_if
// Bus bundle between the L1 cache controller (master) and the L1 register-array
// memory (slave): clear request/busy, packed read ports and the byte-enabled
// write port.
interface l1_reg_mem_mp_if #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int RD_PORTS = 2
);
    localparam int AW = $clog2(DEPTH);

    logic                      clr_req;
    logic                      busy;
    logic [RD_PORTS*AW-1:0]    raddr;
    logic [RD_PORTS*WIDTH-1:0] rdata;
    logic                      wen;
    logic [AW-1:0]             waddr;
    logic [WIDTH/8-1:0]        wbe;
    logic [WIDTH-1:0]          wdata;

    modport master (
        output clr_req, raddr, wen, waddr, wbe, wdata,
        input  busy, rdata
    );

    modport slave (
        input  clr_req, raddr, wen, waddr, wbe, wdata,
        output busy, rdata
    );
endinterface

// File: rtl/l1_reg_mem_mp.sv
// l1_reg_mem_mp
// Register-array storage for L1 tag/data/status. RD_PORTS combinational read
// ports, one synchronous byte-enabled write port. The array itself has no reset;
// a clear engine walks every entry (one per cycle) after rst_n or on clr_req,
// and busy is held high for exactly DEPTH cycles while it runs. Reads return 0
// and writes are dropped while busy.
// Optional build macro: L1_REG_MEM_BYPASS_EN enables combinational write-through
// forwarding from the write port to any read port addressing the same entry.
module l1_reg_mem_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 1024,
    parameter int RD_PORTS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    l1_reg_mem_mp_if.slave    bus
);
    localparam int            AW       = $clog2(DEPTH);
    localparam int            NB       = WIDTH / 8;
    localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    state_e             state_q;
    logic [AW-1:0]      clr_cnt_q;
    logic [AW-1:0]      clr_cnt_d;
    logic               busy_q;
    logic               wr_ok;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    // Per-byte merge: byte i comes from nw when be[i] is set, else from old.
    function automatic logic [WIDTH-1:0] byte_merge(
        input logic [WIDTH-1:0] old,
        input logic [WIDTH-1:0] nw,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] r;
        r = old;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[8*i +: 8] = nw[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign clr_cnt_d = clr_cnt_q + 1'b1;
    assign wr_ok     = (state_q == ST_IDLE) && bus.wen && addr_ok(bus.waddr);
    assign bus.busy  = busy_q;

    // Clear-engine FSM: INIT walks the counter over every entry, IDLE waits for clr_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q   <= ST_IDLE;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_d;
                    end
                end
                ST_IDLE: begin
                    // A clear request arriving while INIT runs is never seen here,
                    // so the counter cannot be restarted mid-clear by clr_req.
                    if (bus.clr_req) begin
                        state_q   <= ST_INIT;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    clr_cnt_q <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    // Array update: the clear engine owns the write path in INIT, the bus in IDLE.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.waddr] <= byte_merge(mem_q[bus.waddr], bus.wdata, bus.wbe);
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic             ra_ok;
        logic [WIDTH-1:0] stored;
        logic [WIDTH-1:0] val;

        assign ra     = bus.raddr[p*AW +: AW];
        assign ra_ok  = addr_ok(ra);
        assign stored = ra_ok ? mem_q[ra] : '0;

`ifdef L1_REG_MEM_BYPASS_EN
        // Forward the in-flight write so a same-cycle reader sees the new bytes.
        logic hit;
        assign hit = !busy_q && bus.wen && ra_ok && (ra == bus.waddr);
        assign val = hit ? byte_merge(stored, bus.wdata, bus.wbe) : stored;
`else
        // No forwarding: the reader sees the pre-write entry this cycle.
        assign val = stored;
`endif

        assign bus.rdata[p*WIDTH +: WIDTH] = busy_q ? '0 : val;
    end

endmodule

// File: tb/tb_l1_reg_mem_mp.sv
// tb_l1_reg_mem_mp
// Directed plus randomized bench for l1_reg_mem_mp. The reference model keeps an
// array of entries and a count of remaining busy cycles; a clear is modelled as
// an instant wipe of the whole array followed by DEPTH busy cycles, which is
// observationally equivalent because reads are masked and writes dropped while busy.
module tb_l1_reg_mem_mp;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 20;
    localparam int RD_PORTS = 2;
    localparam int AW       = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    l1_reg_mem_mp_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS)) bus ();

    l1_reg_mem_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_PORTS(RD_PORTS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int               checks = 0;
    int               errors = 0;
    int               busy_left;
    int               n;
    logic [WIDTH-1:0] model_mem [DEPTH];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_left = DEPTH;
        foreach (model_mem[i]) model_mem[i] = '0;
    endtask

    function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        if (busy_left > 0) return '0;
        if (int'(a) >= DEPTH) return '0;
        v = model_mem[a];
`ifdef L1_REG_MEM_BYPASS_EN
        if (bus.wen && bus.waddr == a) begin
            for (int i = 0; i < WIDTH/8; i++)
                if (bus.wbe[i]) v[8*i +: 8] = bus.wdata[8*i +: 8];
        end
`endif
        return v;
    endfunction

    // What a rising edge does to the model, given the inputs currently driven.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (bus.wen && int'(bus.waddr) < DEPTH) begin
                for (int i = 0; i < WIDTH/8; i++)
                    if (bus.wbe[i]) model_mem[bus.waddr][8*i +: 8] = bus.wdata[8*i +: 8];
            end
            if (bus.clr_req) begin
                foreach (model_mem[i]) model_mem[i] = '0;
                busy_left = DEPTH;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [3:0] be,
                         input logic [WIDTH-1:0] wd, input logic [AW-1:0] r0,
                         input logic [AW-1:0] r1, input logic clr);
        bus.wen     = w;
        bus.waddr   = wa;
        bus.wbe     = be;
        bus.wdata   = wd;
        bus.raddr   = {r1, r0};
        bus.clr_req = clr;
    endtask

    task automatic check_all();
        #1;
        chk("busy", WIDTH'(bus.busy), WIDTH'(busy_left > 0));
        for (int p = 0; p < RD_PORTS; p++)
            chk($sformatf("rdata%0d", p), bus.rdata[p*WIDTH +: WIDTH], exp_rd(bus.raddr[p*AW +: AW]));
    endtask

    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [3:0] be,
                        input logic [WIDTH-1:0] wd, input logic [AW-1:0] r0,
                        input logic [AW-1:0] r1, input logic clr);
        drive(w, wa, be, wd, r0, r1, clr);
        check_all();
        tick();
    endtask

    // Runs random (dropped) writes while busy; cnt = cycles busy stayed high.
    task automatic wait_idle(output int cnt, input int clr_at);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < DEPTH + 10) begin
            drive(1'b1, AW'($urandom_range(0, DEPTH-1)), 4'($urandom), $urandom,
                  AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1)),
                  cnt == clr_at);
            check_all();
            tick();
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        tick();
        check_all();
        tick();

        // Reset release: busy for DEPTH cycles, writes during that time dropped.
        rst_n = 1'b1;
        wait_idle(n, -1);
        chk("busy_len_reset", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, AW'(a), AW'(DEPTH-1-a), 1'b0);

        // Byte-enabled write, then an all-zero byte enable.
        step(1'b1, 5, 4'b0101, 32'hAABBCCDD, 0, 0, 1'b0);
        drive(1'b0, '0, '0, '0, 5, 5, 1'b0);
        check_all();
        chk("wbe_merge", bus.rdata[31:0], 32'h00BB00DD);
        tick();
        step(1'b1, 5, 4'b0000, 32'hFFFFFFFF, 5, 5, 1'b0);
        drive(1'b0, '0, '0, '0, 5, 5, 1'b0);
        check_all();
        chk("wbe_zero", bus.rdata[63:32], 32'h00BB00DD);
        tick();

        // Two ports reading two different entries together.
        step(1'b1, 3, 4'hF, 32'h11111111, 0, 0, 1'b0);
        step(1'b1, 7, 4'hF, 32'h22222222, 0, 0, 1'b0);
        drive(1'b0, '0, '0, '0, 3, 7, 1'b0);
        check_all();
        chk("port0_addr3", bus.rdata[31:0], 32'h11111111);
        chk("port1_addr7", bus.rdata[63:32], 32'h22222222);
        tick();

        // Same-cycle read and write of one address.
        drive(1'b1, 9, 4'hF, 32'hCAFEF00D, 9, 9, 1'b0);
        check_all();
`ifdef L1_REG_MEM_BYPASS_EN
        chk("raw_same_cycle", bus.rdata[31:0], 32'hCAFEF00D);
`else
        chk("raw_same_cycle", bus.rdata[31:0], 32'h00000000);
`endif
        tick();
        drive(1'b0, '0, '0, '0, 9, 9, 1'b0);
        check_all();
        chk("raw_next_cycle", bus.rdata[63:32], 32'hCAFEF00D);
        tick();

        // Out-of-range read and write.
        step(1'b1, 25, 4'hF, 32'hDEADBEEF, 25, 5, 1'b0);
        drive(1'b0, '0, '0, '0, 25, 31, 1'b0);
        check_all();
        chk("oor_read", bus.rdata[31:0], 32'h00000000);
        tick();

        // Randomized traffic with occasional clears.
        for (int k = 0; k < 400; k++)
            step(1'($urandom), AW'($urandom), 4'($urandom), $urandom, AW'($urandom), AW'($urandom),
                 $urandom_range(0, 99) == 0);
        wait_idle(n, -1);

        // Fill everything, clear, re-request mid-clear.
        for (int a = 0; a < DEPTH; a++) step(1'b1, AW'(a), 4'hF, $urandom | 32'h1, 0, 0, 1'b0);
        step(1'b0, '0, '0, '0, 0, 0, 1'b1);
        wait_idle(n, 10);
        chk("busy_len_clr", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, '0, '0, '0, AW'(a), AW'(a), 1'b0);
            check_all();
            chk("clr_zero", bus.rdata[31:0], '0);
            tick();
        end

        // Reset pulse halfway through a clear.
        step(1'b1, 4, 4'hF, 32'h12345678, 0, 0, 1'b0);
        step(1'b0, '0, '0, '0, 4, 4, 1'b1);
        for (int k = 0; k < DEPTH/2 - 1; k++) step(1'b0, '0, '0, '0, 4, 4, 1'b0);
        rst_n = 1'b0;
        model_reset();
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
        wait_idle(n, -1);
        chk("busy_len_midrst", n, DEPTH);
        drive(1'b0, '0, '0, '0, 4, 4, 1'b0);
        check_all();
        chk("midrst_zero", bus.rdata[31:0], 32'h00000000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
